div_issue_ctrl: RTL and testbench

Execute-stage requester for the shared iterative divider. It owns the initiator side of the divider's start/annul/ready handshake, and it decodes DIV/DIVU in EX. It latches the operands and holds the pipeline stalled until the quotient and remainder return. On completion it issues a single HI/LO write. On a pipeline flush it cancels or drains the divider so that no stale result reaches a later request.

---
 rtl/div_issue_ctrl.sv | 114 +++++++++++
 tb/tb_div_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the shared iterative divider: latches DIV/DIVU operands,
// stalls the pipeline until the result returns, then issues one HI/LO write.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_div_i,
    input  logic        op_divu_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        hi_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_DONE   = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_drain_cnt;
    logic        r_start;
    logic        r_signed;
    logic [31:0] r_opdata1;
    logic [31:0] r_opdata2;
    logic        r_hi_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_req;

    assign w_req = op_div_i | op_divu_i;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 1'b0;
            r_start     <= 1'b0;
            r_signed    <= 1'b0;
            r_opdata1   <= 32'd0;
            r_opdata2   <= 32'd0;
            r_hi_we     <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            r_hi_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !flush_i) begin
                        r_opdata1 <= rs_data_i;
                        r_opdata2 <= rt_data_i;
                        r_signed  <= op_div_i;
                        r_start   <= 1'b1;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Flush wins over a same-cycle ready: the result is dropped.
                    if (flush_i) begin
                        r_start     <= 1'b0;
                        r_drain_cnt <= 1'b0;
                        r_state     <= S_CANCEL;
                    end else if (div_ready_i) begin
                        r_hi    <= div_result_i[63:32];
                        r_lo    <= div_result_i[31:0];
                        r_hi_we <= 1'b1;
                        r_start <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_CANCEL: begin
                    // Two annul cycles also clear a divider parked in by-zero/end.
                    if (r_drain_cnt) begin
                        r_drain_cnt <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_req_o   = ((r_state == S_IDLE) && w_req && !flush_i)
                         || (r_state == S_BUSY)
                         || ((r_state == S_CANCEL) && w_req);
    assign div_annul_o   = ((r_state == S_BUSY) && flush_i) || (r_state == S_CANCEL);
    assign div_start_o   = r_start;
    assign div_signed_o  = r_signed;
    assign div_opdata1_o = r_opdata1;
    assign div_opdata2_o = r_opdata2;
    assign hi_we_o       = r_hi_we & ~flush_i;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: divider stub, transaction-level reference model with a
// per-cycle comparator, and directed scenarios with hand-computed results.
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        op_div_i;
    logic        op_divu_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        hi_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_errors = 0;

    div_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .op_div_i     (op_div_i),
        .op_divu_i    (op_divu_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .flush_i      (flush_i),
        .stall_req_o  (stall_req_o),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .hi_we_o      (hi_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mips_div(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Divider stub: ready after 36 start cycles (4 for a zero divisor), held while start stays high.
    int stub_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) stub_cnt <= 0;
        else if (!div_start_o || div_annul_o) stub_cnt <= 0;
        else stub_cnt <= stub_cnt + 1;
    end
    assign div_ready_i  = div_start_o && (stub_cnt >= ((div_opdata2_o == 32'd0) ? 3 : 35));
    assign div_result_i = mips_div(div_opdata1_o, div_opdata2_o, div_signed_o);

    // Reference model: a request is either waiting in the divider, just completed,
    // or being drained for a number of cycles; everything else is idle.
    logic        m_busy;
    logic        m_done;
    int          m_cancel_left;
    logic        m_sgn;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;  m_done <= 1'b0;  m_cancel_left <= 0;  m_sgn <= 1'b0;
            m_op1  <= 32'd0; m_op2  <= 32'd0; m_hi <= 32'd0;       m_lo  <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush_i) begin
                    m_busy        <= 1'b0;
                    m_cancel_left <= 2;
                end else if (div_ready_i) begin
                    m_busy         <= 1'b0;
                    m_done         <= 1'b1;
                    {m_hi, m_lo}   <= mips_div(m_op1, m_op2, m_sgn);
                end
            end else if (m_cancel_left > 0) begin
                m_cancel_left <= m_cancel_left - 1;
            end else if (!m_done && (op_div_i || op_divu_i) && !flush_i) begin
                m_busy <= 1'b1;
                m_op1  <= rs_data_i;
                m_op2  <= rt_data_i;
                m_sgn  <= op_div_i;
            end
        end
    end

    always @(negedge clk) begin
        logic m_idle;
        logic req;
        m_idle = !m_busy && (m_cancel_left == 0) && !m_done;
        req    = op_div_i || op_divu_i;
        check("stall_req_o",   stall_req_o,
              (m_idle && req && !flush_i) || m_busy || ((m_cancel_left > 0) && req));
        check("div_start_o",   div_start_o, m_busy);
        check("div_annul_o",   div_annul_o, (m_busy && flush_i) || (m_cancel_left > 0));
        check("hi_we_o",       hi_we_o, m_done && !flush_i);
        check("div_signed_o",  div_signed_o, m_sgn);
        check("div_opdata1_o", div_opdata1_o, m_op1);
        check("div_opdata2_o", div_opdata2_o, m_op2);
        check("hi_o",          hi_o, m_hi);
        check("lo_o",          lo_o, m_lo);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request from the current cycle (cycle 0) until its HI/LO write,
    // checking stall length and write cycle, then retires it from EX.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall);
        int n_stall;
        int we_cycle;
        op_div_i  = sgn;
        op_divu_i = !sgn;
        rs_data_i = a;
        rt_data_i = b;
        n_stall   = 0;
        we_cycle  = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall_req_o) n_stall++;
            if (hi_we_o) begin
                we_cycle = c;
                break;
            end
            next_cycle();
        end
        check({name, "_stall_cycles"}, n_stall, exp_stall);
        check({name, "_we_cycle"}, we_cycle, exp_stall);
        next_cycle();
        op_div_i  = 1'b0;
        op_divu_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b0;
        op_div_i  = 1'b0;
        op_divu_i = 1'b0;
        rs_data_i = 32'd0;
        rt_data_i = 32'd0;
        flush_i   = 1'b0;
        repeat (3) next_cycle();
        check("reset_stall", stall_req_o, 0);
        check("reset_start", div_start_o, 0);
        check("reset_annul", div_annul_o, 0);
        check("reset_hi_we", hi_we_o, 0);
        check("reset_hi_lo", {hi_o, lo_o}, 64'd0);
        rst = 1'b1;
        next_cycle();

        // DIVU 100/7
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 37);
        check("divu_100_7_lo", lo_o, 32'd14);
        check("divu_100_7_hi", hi_o, 32'd2);
        @(negedge clk);
        check("after_done_stall", stall_req_o, 0);
        check("after_done_we", hi_we_o, 0);
        next_cycle();

        // Back-to-back DIV and DIVU of -7 / 2: second request is seen in cycle 38.
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 37);
        check("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
        run_op("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 37);
        check("divu_m7_2_lo", lo_o, 32'h7FFF_FFFC);
        check("divu_m7_2_hi", hi_o, 32'd1);
        next_cycle();

        // Divide by zero
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 5);
        check("div_5_0_hilo", {hi_o, lo_o}, 64'd0);
        next_cycle();

        // Flush in BUSY cycle 10, DIVU 9/3 requested in cycle 11
        op_divu_i = 1'b1; rs_data_i = 32'd100; rt_data_i = 32'd7;
        repeat (10) next_cycle();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_c10_annul", div_annul_o, 1);
        check("flush_c10_we", hi_we_o, 0);
        next_cycle();
        flush_i = 1'b0; rs_data_i = 32'd9; rt_data_i = 32'd3;
        @(negedge clk);
        check("flush_c11_annul", div_annul_o, 1);
        check("flush_c11_stall", stall_req_o, 1);
        check("flush_c11_start", div_start_o, 0);
        next_cycle();
        @(negedge clk);
        check("flush_c12_annul", div_annul_o, 1);
        check("flush_c12_we", hi_we_o, 0);
        next_cycle();
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 37);
        check("divu_9_3_lo", lo_o, 32'd3);
        check("divu_9_3_hi", hi_o, 32'd0);
        next_cycle();

        // Zero-divisor DIV flushed in cycle 2, DIVU 8/2 follows
        op_div_i = 1'b1; rs_data_i = 32'd5; rt_data_i = 32'd0;
        repeat (2) next_cycle();
        flush_i = 1'b1;
        @(negedge clk);
        check("zflush_c2_annul", div_annul_o, 1);
        next_cycle();
        flush_i = 1'b0; op_div_i = 1'b0; op_divu_i = 1'b1;
        rs_data_i = 32'd8; rt_data_i = 32'd2;
        @(negedge clk);
        check("zflush_c3_we", hi_we_o, 0);
        check("zflush_c3_stall", stall_req_o, 1);
        next_cycle();
        @(negedge clk);
        check("zflush_c4_we", hi_we_o, 0);
        check("zflush_c4_annul", div_annul_o, 1);
        next_cycle();
        run_op("divu_8_2", 1'b0, 32'd8, 32'd2, 37);
        check("divu_8_2_lo", lo_o, 32'd4);
        check("divu_8_2_hi", hi_o, 32'd0);
        next_cycle();

        // Asynchronous reset in BUSY cycle 20
        op_divu_i = 1'b1; rs_data_i = 32'd100; rt_data_i = 32'd7;
        repeat (20) next_cycle();
        check("pre_reset_start", div_start_o, 1);
        #1;
        rst = 1'b0; op_divu_i = 1'b0;
        #1;
        check("async_rst_stall", stall_req_o, 0);
        check("async_rst_start", div_start_o, 0);
        check("async_rst_annul", div_annul_o, 0);
        check("async_rst_signed", div_signed_o, 0);
        check("async_rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
        check("async_rst_we", hi_we_o, 0);
        check("async_rst_hilo", {hi_o, lo_o}, 64'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        run_op("divu_6_3", 1'b0, 32'd6, 32'd3, 37);
        check("divu_6_3_lo", lo_o, 32'd2);
        check("divu_6_3_hi", hi_o, 32'd0);
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
